// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, LSB-first, one bit per clock.
// Optional two's-complement overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               br_q, br_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               d_bit_c;
  logic               br_next_c;
`ifdef SERIAL_SUB_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  // Single full-subtractor stage on the current operand LSBs.
  always_comb begin
    d_bit_c   = a_q[0] ^ b_q[0] ^ br_q;
    br_next_c = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      // DONE accepts a new start exactly like IDLE, so ops can run back to back.
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {d_bit_c, res_q[WIDTH-1:1]};
        br_d  = br_next_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d  = {d_bit_c, res_q[WIDTH-1:1]};
          bout_d  = br_next_c;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) & (d_bit_c != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner sequences, random ops.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int ua, ub, sa, sb, sr;
    ua = int'(ai);
    ub = int'(bi);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    sr = sa - sb - int'(bini);
    d  = W'((ua - ub - int'(bini)) & 255);
    bo = (ua < ub + int'(bini));
    ov = (sr < -128) || (sr > 127);
  endtask

  // Start one op, scramble inputs after capture, check busy/latency, return results at done.
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int k;
    int busy_n;
    @(negedge clk);
    a = ai; b = bi; bin = bini; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    k = 0;
    busy_n = 0;
    while (!done && k < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(W));
    chk("busy_cycles", 32'(busy_n), 32'(W));
    chk("busy_in_done", 32'(busy), 32'd0);
    d  = diff;
    bo = bout;
    ov = get_ovf();
  endtask

  initial begin
    vec_t         vecs[8];
    logic [W-1:0] d, ed, ai, bi, prev_d;
    logic         bo, ov, ebo, eov, bini;
    int           k, done_n;

    vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, bin: 1'b0, d: 8'h00, bo: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bo: 1'b1, ov: 1'b1};
    vecs[6] = '{a: 8'h5A, b: 8'h5A, bin: 1'b0, d: 8'h00, bo: 1'b0, ov: 1'b0};
    vecs[7] = '{a: 8'h00, b: 8'hFF, bin: 1'b1, d: 8'h00, bo: 1'b1, ov: 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table; consecutive ops start in the DONE cycle of the previous one.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, ov);
      chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].d));
      chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bo));
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ov));
`endif
    end

    // done is a single pulse and diff holds while idle.
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("diff_hold", 32'(diff), 32'h00);

    // Start re-pulsed mid-SHIFT with new operands is ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    repeat (2) begin @(posedge clk); #1; k++; end
    @(negedge clk);
    a = 8'hAA; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    k++;
    start = 1'b0;
    while (!done && k < 40) begin @(posedge clk); #1; k++; end
    chk("ign_latency", 32'(k), 32'(W));
    chk("ign_diff", 32'(diff), 32'h0F);
    chk("ign_bout", 32'(bout), 32'd0);

    // Start in DONE cycle: SHIFT next cycle, old diff stable during it.
    prev_d = diff;
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    chk("b2b_diff_stable", 32'(diff), 32'(prev_d));
    k = 0;
    while (!done && k < 40) begin @(posedge clk); #1; k++; end
    chk("b2b_latency", 32'(k), 32'(W));
    chk("b2b_diff", 32'(diff), 32'h02);

    // Async reset during the 4th SHIFT cycle.
    @(negedge clk);
    a = 8'hF0; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) done_n++;
    end
    chk("no_done_after_rst", 32'(done_n), 32'd0);
    do_op(8'h05, 8'h03, 1'b0, d, bo, ov);
    chk("post_rst_diff", 32'(d), 32'h02);
    chk("post_rst_bout", 32'(bo), 32'd0);

    // Random ops against the arithmetic reference.
    for (int i = 0; i < 150; i++) begin
      ai   = W'($urandom);
      bi   = W'($urandom);
      bini = 1'($urandom);
      if (i % 10 == 0) bi = ai;
      model(ai, bi, bini, ed, ebo, eov);
      do_op(ai, bi, bini, d, bo, ov);
      chk($sformatf("rnd%0d_diff a=%0h b=%0h bin=%0b", i, ai, bi, bini), 32'(d), 32'(ed));
      chk($sformatf("rnd%0d_bout", i), 32'(bo), 32'(ebo));
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(eov));
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
